// File: rtl/seq_array_divider.sv
// -----------------------------------------------------------------------------
// seq_array_divider
//
// Sequential restoring divider, the inverse of the 4x4 array multiplier that
// sits beside it in the tile top. One quotient bit is produced per clock, MSB
// first, so a division takes DIVIDEND_W cycles in CALC.
//
// Handshake (start/busy/done):
//   - start is sampled only while the FSM is IDLE. The edge that sees start=1
//     in IDLE is the accepting edge; dividend/divisor are latched there and
//     are never looked at again for that operation.
//   - busy is high for every cycle the datapath is iterating (CALC).
//   - done is a single-cycle pulse; quotient/remainder/div_by_zero are valid
//     in that cycle and are held until the next accepted start.
//   - start while CALC or DONE is ignored; the earliest next accept is the
//     edge that ends the cycle after done.
//
// Parameters:
//   DIVIDEND_W  dividend / quotient width (>= 2)
//   DIVISOR_W   divisor / remainder width (>= 1, <= DIVIDEND_W)
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   dividend     numerator, latched on accepted start
//   divisor      denominator, latched on accepted start
//   busy         high while CALC is in progress
//   done         one-cycle pulse, results valid
//   quotient     unsigned quotient (all ones for a zero divisor)
//   remainder    unsigned remainder (dividend low bits for a zero divisor)
//   div_by_zero  divisor was zero, held with the results
//   state_dbg    current FSM state encoding (0=IDLE, 1=CALC, 2=DONE)
//
// Optional feature:
//   DIV_ZERO_SKIP_EN  when defined, a zero divisor bypasses CALC and goes
//                     straight to DONE with the same result values (busy
//                     never asserts). When undefined, a zero divisor runs the
//                     full iteration and the same values fall out naturally.
// -----------------------------------------------------------------------------
module seq_array_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [DIVIDEND_W-1:0]  dq;     // dividend bits shift out of the MSB, quotient bits into the LSB
    logic [DIVISOR_W-1:0]   rem;    // partial remainder, always < dvs when dvs != 0
    logic [DIVISOR_W-1:0]   dvs;    // latched divisor
    logic [CNT_W-1:0]       cnt;    // iterations left minus one

    // One restoring step. Because rem < dvs, r_shift < 2*dvs, so the
    // difference always fits back into DIVISOR_W bits. With dvs == 0 the
    // compare is always true, which yields an all-ones quotient and leaves
    // the last DIVISOR_W dividend bits in rem.
    logic [DIVISOR_W:0]     r_shift;
    logic                   take;
    logic [DIVISOR_W-1:0]   rem_next;
    logic [DIVIDEND_W-1:0]  dq_next;

    always_comb begin
        r_shift  = {rem, dq[DIVIDEND_W-1]};
        take     = (r_shift >= {1'b0, dvs});
        rem_next = r_shift[DIVISOR_W-1:0];
        if (take) begin
            rem_next = DIVISOR_W'(r_shift - {1'b0, dvs});
        end
        dq_next  = {dq[DIVIDEND_W-2:0], take};
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dq          <= '0;
            rem         <= '0;
            dvs         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dq          <= dividend;
                        rem         <= '0;
                        dvs         <= divisor;
                        cnt         <= CNT_W'(DIVIDEND_W - 1);
                        div_by_zero <= (divisor == '0);
`ifdef DIV_ZERO_SKIP_EN
                        if (divisor == '0) begin
                            // Result is known without iterating.
                            quotient  <= '1;
                            remainder <= dividend[DIVISOR_W-1:0];
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
`else
                        busy  <= 1'b1;
                        state <= CALC;
`endif
                    end
                end

                CALC: begin
                    dq  <= dq_next;
                    rem <= rem_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        // Last iteration: publish the step results directly.
                        quotient  <= dq_next;
                        remainder <= rem_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_array_divider
//
// Bench for seq_array_divider (default 8/4 widths). Expected results are
// pushed into exp_q when a start is driven and popped by a monitor on the
// falling edge whenever done is high. Directed cases cover the normal path,
// zero divisor, ignored mid-CALC start, asynchronous reset mid-CALC and
// back-to-back operation; then all 256x16 operand pairs are swept.
// -----------------------------------------------------------------------------
module tb_seq_array_divider;

    localparam int DW = 8;
    localparam int VW = 4;

`ifdef DIV_ZERO_SKIP_EN
    localparam int ZERO_LAT  = 0;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = DW;
    localparam int ZERO_BUSY = DW;
`endif

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic [1:0]    state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_array_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (VW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // exp entry layout: {div_by_zero, remainder, quotient}
    logic [DW+VW:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW+VW:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int q;
        int r;
        if (b == 0) begin
            q = (1 << DW) - 1;
            r = a % (1 << VW);
            return {1'b1, VW'(r), DW'(q)};
        end
        q = a / b;
        r = a % b;
        return {1'b0, VW'(r), DW'(q)};
    endfunction

    always @(negedge clk) begin
        logic [DW+VW:0] e;
        if (rst_n && done) begin
            check("pending_on_done", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("quotient", 32'(quotient), 32'(e[DW-1:0]));
                check("remainder", 32'(remainder), 32'(e[DW+VW-1:DW]));
                check("div_by_zero", 32'(div_by_zero), 32'(e[DW+VW]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen, scrambling
    // the operand inputs meanwhile; then steps past the DONE cycle.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            dividend = DW'($urandom_range(0, (1 << DW) - 1));
            divisor  = VW'($urandom_range(0, (1 << VW) - 1));
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_seen", 32'(done), 1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);
        check("back_to_idle", 32'(state_dbg), 0);
    endtask

    task automatic run_case(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int lat;
        int bc;
        issue(a, b);
        wait_done(lat, bc);
        check("latency", 32'(lat), (b == 0) ? 32'(ZERO_LAT) : 32'(DW));
        check("busy_cycles", 32'(bc), (b == 0) ? 32'(ZERO_BUSY) : 32'(DW));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int bc;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        check("rst_state", 32'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_case(8'd200, 4'd7);
        run_case(8'd255, 4'd15);
        run_case(8'd0,   4'd5);
        run_case(8'd9,   4'd1);
        run_case(8'd13,  4'd0);

        // start during CALC is ignored, inputs too
        issue(8'd100, 4'd3);
        repeat (3) begin
            @(negedge clk);
            start    = 1'b1;
            dividend = 8'd50;
            divisor  = 4'd2;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("midcalc_latency", 32'(lat + 3), 32'(DW));
        repeat (5) begin
            @(negedge clk);
            dividend = DW'($urandom_range(0, 255));
            divisor  = VW'($urandom_range(0, 15));
        end
        check("hold_quotient", 32'(quotient), 33);
        check("hold_remainder", 32'(remainder), 1);

        // asynchronous reset in CALC cycle 4 aborts without done
        issue(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_quotient", 32'(quotient), 0);
        check("abort_remainder", 32'(remainder), 0);
        check("abort_dbz", 32'(div_by_zero), 0);
        check("abort_state", 32'(state_dbg), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done_pending", 32'(exp_q.size()), 0);
        run_case(8'd77, 4'd6);

        // back-to-back: next start accepted the cycle after done
        run_case(8'd143, 4'd11);

        // exhaustive sweep
        for (int a = 0; a < (1 << DW); a++) begin
            for (int b = 0; b < (1 << VW); b++) begin
                run_case(DW'(a), VW'(b));
            end
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_array_divider.md
Name: seq_array_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's 4x4 array multiplier.
- Takes the 8-bit product-width dividend and a 4-bit factor-width divisor. Returns quotient and remainder after one iteration per dividend bit.
- Sits beside the multiplier in the tile top. Top drives ui_in to dividend, uio_in[3:0] to divisor, uio_in[4] to start; results go back through uo_out/uio_out.
- Start/busy/done handshake.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width (>=2)
- DIVISOR_W, 4, divisor and remainder width (>=1, <=DIVIDEND_W)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- dividend  input  DIVIDEND_W  numerator, latched on accepted start
- divisor  input  DIVISOR_W  denominator, latched on accepted start
- busy  output  1  high while CALC in progress
- done  output  1  one-cycle pulse, results valid
- quotient  output  DIVIDEND_W  unsigned quotient, held until next accepted start
- remainder  output  DIVISOR_W  unsigned remainder, held until next accepted start
- div_by_zero  output  1  latched divisor==0 flag, held with results

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and operand registers cleared.
- Reset mid-CALC aborts the operation; no done is issued.
- Internal registers:
  - dq: DIVIDEND_W shift register, initially the dividend; quotient bits shift into its LSB.
  - rem: DIVISOR_W bits.
  - dvs: DIVISOR_W bits.
  - cnt: clog2(DIVIDEND_W) bits.
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - dq<=dividend, rem<=0, dvs<=divisor, cnt<=DIVIDEND_W-1.
  - div_by_zero<=(divisor==0), busy<=1, go to CALC.
  - Operands are sampled only at this edge.
- IDLE, start=0: hold all outputs.
- CALC, each cycle:
  - r_shift = {rem, dq[MSB]} (DIVISOR_W+1 bits).
  - If r_shift >= {1'b0,dvs}: rem<=(r_shift-dvs) truncated to DIVISOR_W, new bit=1; else rem<=r_shift[DIVISOR_W-1:0], new bit=0.
  - dq<={dq[MSB-1:0], new bit}.
  - cnt decrements. On the cnt==0 iteration: go to DONE, busy<=0, done<=1, quotient<=final dq, remainder<=final rem.
- DONE: done high exactly one cycle; next edge done<=0 and state returns to IDLE. start in DONE is ignored.
- Latency: start accepted at edge N; done high during the cycle after edge N+DIVIDEND_W. Next start is accepted at earliest in the cycle after done.
- start during CALC/DONE: ignored, operation unaffected. Input changes during CALC have no effect.
- Divide by zero, required result: quotient=all ones, remainder=dividend[DIVISOR_W-1:0], div_by_zero=1. This falls out of the algorithm naturally.
- Arithmetic is unsigned throughout. Remainder < divisor whenever divisor != 0.

Optional Feature:
- Macro DIV_ZERO_SKIP_EN.
- Defined:
  - IDLE with start=1 and divisor==0 loads quotient=all ones, remainder=dividend[DIVISOR_W-1:0], div_by_zero=1.
  - Goes directly to DONE; busy never asserts.
  - done is high in the cycle after the start edge (latency 1).
- Undefined: the zero divisor runs the full DIVIDEND_W-cycle CALC, with identical result values.
- Nonzero divisors behave identically either way.

Test Plan:
- Reset, then dividend=200, divisor=7, start pulse -> busy 8 cycles, done 1 cycle; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=15 -> quotient=17, remainder=0; dividend=0, divisor=5 -> quotient=0, remainder=0; dividend=9, divisor=1 -> quotient=9, remainder=0.
- dividend=13, divisor=0:
  - Result: quotient=255, remainder=13, div_by_zero=1.
  - Latency: done 8 cycles after start without DIV_ZERO_SKIP_EN; 1 cycle with it, busy never high.
- Start 100/3; mid-CALC drive start=1 with dividend=50, divisor=2 -> ignored; result quotient=33, remainder=1. Outputs hold until the next start.
- Start 200/7; assert rst_n=0 at CALC cycle 4 -> all outputs 0 immediately; no done. After release, 77/6 -> quotient=12, remainder=5.
- Back-to-back: start again the cycle after done, 143/11 -> quotient=13, remainder=0. Exhaustive sweep of all 256x16 pairs against a reference model matches.
